spider_wave_scheduler: RTL

Sequences the spider motion datapath across successive waves. Emits the one-cycle reset_spider pulse that re-spawns the four spiders, then gates their movement with a per-frame step enable whose rate rises each wave. It watches the spiders' alive flags to detect wave clear, inserts an inter-wave gap, and flags game completion after MAX_WAVES waves. It sits between the VGA timing generator, which supplies frame_tick, and the spider motion controller.

---
 rtl/spider_pkg.sv | 33 +++
 rtl/frame_divider.sv | 29 ++
 rtl/spider_wave_scheduler.sv | 128 ++++++++++++
 3 files changed

// File: rtl/spider_pkg.sv
// Shared types and constants for the spider wave scheduler.
// Defaults are also read by the HUD.
package spider_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SPAWN  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_GAP    = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  localparam int NUM_SPIDERS     = 4;
  localparam int DEF_BASE_PERIOD = 4;
  localparam int DEF_MIN_PERIOD  = 1;
  localparam int DEF_GAP_FRAMES  = 60;
  localparam int DEF_MAX_WAVES   = 8;

  // max(minp, base - wave) without wrapping below zero
  function automatic logic [4:0] step_period(
    input logic [3:0] wave,
    input logic [4:0] base,
    input logic [4:0] minp
  );
    logic [4:0] w;
    w = {1'b0, wave};
    if (base > w && (base - w) >= minp)
      return base - w;
    return minp;
  endfunction

endpackage

// File: rtl/frame_divider.sv
// Pause-gated frame_tick counter with a one-cycle
// terminal pulse; wraps to zero on the terminal tick.
module frame_divider (
  input  logic       clk25,
  input  logic       reset_n,
  input  logic       clr,
  input  logic       en,
  input  logic       tick,
  input  logic       pause,
  input  logic [7:0] term,
  output logic       hit
);

  logic [7:0] cnt;
  logic       adv;

  assign adv = en && tick && !pause;
  assign hit = adv && (cnt == term);

  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n)
      cnt <= '0;
    else if (clr || hit)
      cnt <= '0;
    else if (adv)
      cnt <= cnt + 8'd1;
  end

endmodule

// File: rtl/spider_wave_scheduler.sv
// Wave sequencer: spawn pulse, per-frame step enable that
// speeds up each wave, clear detection and inter-wave gap.
module spider_wave_scheduler
  import spider_pkg::*;
#(
  parameter int BASE_PERIOD = DEF_BASE_PERIOD,
  parameter int MIN_PERIOD  = DEF_MIN_PERIOD,
  parameter int GAP_FRAMES  = DEF_GAP_FRAMES,
  parameter int MAX_WAVES   = DEF_MAX_WAVES
) (
  input  logic                   clk25,
  input  logic                   reset_n,
  input  logic                   frame_tick,
  input  logic                   start,
  input  logic                   pause,
  input  logic                   abort,
  input  logic [NUM_SPIDERS-1:0] spider_alive_vec,
  output logic                   reset_spider,
  output logic                   step_en,
  output logic [3:0]             wave_num,
  output logic                   wave_active,
  output logic                   game_done,
  output logic [2:0]             state_o
);

  localparam logic [3:0] LAST_WAVE = 4'(MAX_WAVES - 1);
  localparam logic [7:0] GAP_TERM  = 8'(GAP_FRAMES - 1);

  state_t     state;
  logic [4:0] period;
  logic       all_dead;
  logic       step_hit;
  logic       gap_hit;

  assign all_dead = (spider_alive_vec == '0);
  assign period   = step_period(wave_num,
                      5'(BASE_PERIOD), 5'(MIN_PERIOD));
  assign state_o  = state;

  // Clear wins over a same-cycle tick, so the step
  // counter is held off once every spider is dead.
  frame_divider u_step (
    .clk25   (clk25),
    .reset_n (reset_n),
    .clr     (abort || state != ST_RUN),
    .en      (state == ST_RUN && !all_dead),
    .tick    (frame_tick),
    .pause   (pause),
    .term    ({3'b000, period - 5'd1}),
    .hit     (step_hit)
  );

  frame_divider u_gap (
    .clk25   (clk25),
    .reset_n (reset_n),
    .clr     (abort || state != ST_GAP),
    .en      (state == ST_GAP),
    .tick    (frame_tick),
    .pause   (pause),
    .term    (GAP_TERM),
    .hit     (gap_hit)
  );

  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      reset_spider <= 1'b0;
      step_en      <= 1'b0;
      wave_num     <= '0;
      wave_active  <= 1'b0;
      game_done    <= 1'b0;
    end else if (abort) begin
      state        <= ST_IDLE;
      reset_spider <= 1'b0;
      step_en      <= 1'b0;
      wave_num     <= '0;
      wave_active  <= 1'b0;
      game_done    <= 1'b0;
    end else begin
      reset_spider <= 1'b0;
      step_en      <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            state        <= ST_SPAWN;
            wave_num     <= '0;
            reset_spider <= 1'b1;
          end
        end
        ST_SPAWN: begin
          state       <= ST_SETTLE;
          wave_active <= 1'b1;
        end
        ST_SETTLE: state <= ST_RUN;
        ST_RUN: begin
          if (all_dead) begin
            state       <= ST_GAP;
            wave_active <= 1'b0;
          end else begin
            step_en <= step_hit;
          end
        end
        ST_GAP: begin
          if (gap_hit) begin
            if (wave_num == LAST_WAVE) begin
              state     <= ST_DONE;
              game_done <= 1'b1;
            end else begin
              state        <= ST_SPAWN;
              wave_num     <= wave_num + 4'd1;
              reset_spider <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (start) begin
            state        <= ST_SPAWN;
            wave_num     <= '0;
            game_done    <= 1'b0;
            reset_spider <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
